// File: rtl/cheshire_rst_boot_seq_if.sv
// rtl/cheshire_rst_boot_seq_if.sv - strap, warm-reset and per-domain reset bundle of the boot sequencer
interface cheshire_rst_boot_seq_if #(
    parameter int unsigned NumDomains    = 2,
    parameter int unsigned BootModeWidth = 2
);
    logic                     test_mode_i;
    logic [BootModeWidth-1:0] boot_mode_i;
    logic                     sw_rst_req_i;
    logic [BootModeWidth-1:0] boot_mode_o;
    logic                     boot_mode_valid_o;
    logic [NumDomains-1:0]    rst_no;
    logic                     seq_done_o;
    logic                     busy_o;

    modport master (
        input  test_mode_i, boot_mode_i, sw_rst_req_i,
        output boot_mode_o, boot_mode_valid_o, rst_no, seq_done_o, busy_o
    );

    modport slave (
        output test_mode_i, boot_mode_i, sw_rst_req_i,
        input  boot_mode_o, boot_mode_valid_o, rst_no, seq_done_o, busy_o
    );
endinterface

// File: rtl/cheshire_rst_boot_seq.sv
// rtl/cheshire_rst_boot_seq.sv - boot-strap latch and staggered multi-domain reset sequencer
// CHESHIRE_RST_SEQ_BOOT_RESAMPLE_EN: a warm reset re-captures the boot straps before holding.
module cheshire_rst_boot_seq #(
    parameter int unsigned NumDomains    = 2,
    parameter int unsigned BootModeWidth = 2,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned HoldCycles    = 16,
    parameter int unsigned StaggerCycles = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    cheshire_rst_boot_seq_if.master  bus
);
    localparam int unsigned MaxHs  = (HoldCycles > StaggerCycles) ? HoldCycles : StaggerCycles;
    localparam int unsigned MaxCnt = (MaxHs > SyncStages) ? MaxHs : SyncStages;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    typedef enum logic [1:0] {SAMPLE, HOLD, RELEASE, RUN} state_e;

    state_e                                       state_q, state_d;
    logic [CntW-1:0]                              cnt_q, cnt_d;
    logic [IdxW-1:0]                              idx_q, idx_d;
    logic [SyncStages-2:0][BootModeWidth-1:0]     bm_sync_q, bm_sync_d;
    logic [SyncStages-2:0]                        req_sync_q, req_sync_d;
    logic [BootModeWidth-1:0]                     boot_mode_q, boot_mode_d;
    logic                                         valid_q, valid_d;
    logic [NumDomains-1:0]                        rst_q, rst_d;
    logic                                         done_q, done_d;
    logic                                         busy_q, busy_d;
    logic                                         req;

    // The consuming register (boot_mode_q or the FSM) is the last synchroniser stage.
    assign req = req_sync_q[SyncStages-2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        boot_mode_d = boot_mode_q;
        valid_d     = valid_q;
        rst_d       = rst_q;
        done_d      = done_q;
        busy_d      = busy_q;

        bm_sync_d     = bm_sync_q;
        req_sync_d    = req_sync_q;
        bm_sync_d[0]  = bus.boot_mode_i;
        req_sync_d[0] = bus.sw_rst_req_i;
        for (int i = 1; i < int'(SyncStages) - 1; i++) begin
            bm_sync_d[i]  = bm_sync_q[i-1];
            req_sync_d[i] = req_sync_q[i-1];
        end

        case (state_q)
            SAMPLE: begin
                if (cnt_q == CntW'(SyncStages - 1)) begin
                    boot_mode_d = bm_sync_q[SyncStages-2];
                    valid_d     = 1'b1;
                    state_d     = HOLD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            HOLD: begin
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == CntW'(HoldCycles - 1)) begin
                    rst_d[0] = 1'b1;
                    cnt_d    = '0;
                    idx_d    = IdxW'(1);
                    if (NumDomains == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RELEASE: begin
                if (req) begin
                    rst_d   = '0;
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(StaggerCycles - 1)) begin
                    rst_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    if (idx_q == IdxW'(NumDomains - 1)) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RUN: begin
                if (req) begin
                    rst_d  = '0;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                    cnt_d  = '0;
`ifdef CHESHIRE_RST_SEQ_BOOT_RESAMPLE_EN
                    valid_d = 1'b0;
                    state_d = SAMPLE;
`else
                    state_d = HOLD;
`endif
                end
            end
            default: begin
                state_d = SAMPLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SAMPLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            bm_sync_q   <= '0;
            req_sync_q  <= '0;
            boot_mode_q <= '0;
            valid_q     <= 1'b0;
            rst_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            bm_sync_q   <= bm_sync_d;
            req_sync_q  <= req_sync_d;
            boot_mode_q <= boot_mode_d;
            valid_q     <= valid_d;
            rst_q       <= rst_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Test mode is a plain mux so the pin reset reaches every domain without a clock.
    assign bus.rst_no            = bus.test_mode_i ? {NumDomains{rst_ni}} : rst_q;
    assign bus.boot_mode_o       = boot_mode_q;
    assign bus.boot_mode_valid_o = valid_q;
    assign bus.seq_done_o        = done_q;
    assign bus.busy_o            = busy_q;
endmodule

// File: tb/tb_cheshire_rst_boot_seq.sv
// tb/tb_cheshire_rst_boot_seq.sv - randomized timestamp-model bench for cheshire_rst_boot_seq
module tb_cheshire_rst_boot_seq;
    localparam int N   = 2;
    localparam int W   = 2;
    localparam int S   = 2;
    localparam int H   = 16;
    localparam int ST  = 8;
    localparam int FAR = 1 << 28;
    localparam int HL  = 2048;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    cheshire_rst_boot_seq_if #(.NumDomains(N), .BootModeWidth(W)) bus ();

    cheshire_rst_boot_seq #(
        .NumDomains    (N),
        .BootModeWidth (W),
        .SyncStages    (S),
        .HoldCycles    (H),
        .StaggerCycles (ST)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model: k = edges since reset release, t0 = edge the current hold began,
    // sample_end = edge at which straps are (re)captured.
    int           k;
    int           t0;
    int           sample_end;
    logic [W-1:0] bm_exp;
    logic         valid_exp;
    logic [W-1:0] bm_hist [HL];
    logic         req_hist[HL];
    logic         tm_cur;

    function automatic int rel_at(input int x);
        int r;
        if (x < t0 + H) return 0;
        r = (x - t0 - H) / ST + 1;
        return (r > N) ? N : r;
    endfunction

    task automatic model_reset();
        k          = 0;
        t0         = FAR;
        sample_end = S;
        bm_exp     = '0;
        valid_exp  = 1'b0;
    endtask

    task automatic model_edge();
        int   j;
        logic r;
        k++;
        j = k - S + 1;
        r = (j >= 1 && j < HL) ? req_hist[j] : 1'b0;
        if (k == sample_end) begin
            bm_exp    = bm_hist[k-S+1];
            valid_exp = 1'b1;
            t0        = k;
        end else if (k > sample_end && r) begin
`ifdef CHESHIRE_RST_SEQ_BOOT_RESAMPLE_EN
            if (rel_at(k - 1) == N) begin
                valid_exp  = 1'b0;
                sample_end = k + S;
                t0         = FAR;
            end else begin
                t0 = k;
            end
`else
            t0 = k;
`endif
        end
    endtask

    task automatic check_all(input string ph);
        int           rel;
        logic [N-1:0] rexp;
        rel = rel_at(k);
        for (int i = 0; i < N; i++) rexp[i] = (i < rel);
        if (tm_cur) rexp = {N{rst_ni}};
        check_eq($sformatf("%s_rst_no_k%0d", ph, k), 32'(bus.rst_no), 32'(rexp));
        check_eq($sformatf("%s_boot_mode_k%0d", ph, k), 32'(bus.boot_mode_o), 32'(bm_exp));
        check_eq($sformatf("%s_valid_k%0d", ph, k), 32'(bus.boot_mode_valid_o), 32'(valid_exp));
        check_eq($sformatf("%s_done_k%0d", ph, k), 32'(bus.seq_done_o), 32'(rel == N));
        check_eq($sformatf("%s_busy_k%0d", ph, k), 32'(bus.busy_o), 32'(rel != N));
    endtask

    task automatic cycle(input logic [W-1:0] bm, input logic req, input logic tm);
        @(negedge clk);
        check_all("cyc");
        bus.boot_mode_i  = bm;
        bus.sw_rst_req_i = req;
        bus.test_mode_i  = tm;
        tm_cur           = tm;
        if (k + 1 < HL) begin
            bm_hist[k+1]  = bm;
            req_hist[k+1] = req;
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic do_reset(input logic [W-1:0] bm);
        @(negedge clk);
        rst_ni           = 1'b0;
        bus.boot_mode_i  = bm;
        bus.sw_rst_req_i = 1'b0;
        bus.test_mode_i  = 1'b0;
        tm_cur           = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        repeat (2) @(negedge clk);
        rst_ni      = 1'b1;
        bm_hist[1]  = bm;
        req_hist[1] = 1'b0;
        @(posedge clk);
        model_edge();
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq({tag, "_rst_no"}, 32'(bus.rst_no), 32'(0));
        check_eq({tag, "_valid"}, 32'(bus.boot_mode_valid_o), 32'(0));
        check_eq({tag, "_boot_mode"}, 32'(bus.boot_mode_o), 32'(0));
        check_eq({tag, "_done"}, 32'(bus.seq_done_o), 32'(0));
        check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'(1));
    endtask

    logic [W-1:0] bm_cur;
    logic         rq;
    int           req_left;
    int           len;
    int           tm_start;
    int           rst_pt;

    initial begin
        rst_ni           = 1'b0;
        bus.boot_mode_i  = '0;
        bus.sw_rst_req_i = 1'b0;
        bus.test_mode_i  = 1'b0;
        tm_cur           = 1'b0;
        model_reset();

        // Cold boot, strap change after capture, warm reset acting at edge 40.
        do_reset(2'b10);
        bm_cur = 2'b10;
        while (k < 80) begin
            if (k == 4) bm_cur = 2'b01;
            cycle(bm_cur, (k == 40 - S), 1'b0);
            #1;
            if (k == 1)  check_eq("plan_valid_e1", 32'(bus.boot_mode_valid_o), 32'(0));
            if (k == 2)  check_eq("plan_valid_e2", 32'(bus.boot_mode_valid_o), 32'(1));
            if (k == 2)  check_eq("plan_bm_e2", 32'(bus.boot_mode_o), 32'(2'b10));
            if (k == 17) check_eq("plan_rst_e17", 32'(bus.rst_no), 32'(2'b00));
            if (k == 18) check_eq("plan_rst_e18", 32'(bus.rst_no), 32'(2'b01));
            if (k == 25) check_eq("plan_done_e25", 32'(bus.seq_done_o), 32'(0));
            if (k == 26) check_eq("plan_rst_e26", 32'(bus.rst_no), 32'(2'b11));
            if (k == 26) check_eq("plan_done_e26", 32'(bus.seq_done_o), 32'(1));
            if (k == 26) check_eq("plan_busy_e26", 32'(bus.busy_o), 32'(0));
            if (k == 30) check_eq("plan_bm_e30", 32'(bus.boot_mode_o), 32'(2'b10));
            if (k == 40) check_eq("plan_rst_e40", 32'(bus.rst_no), 32'(2'b00));
            if (k == 40) check_eq("plan_busy_e40", 32'(bus.busy_o), 32'(1));
`ifdef CHESHIRE_RST_SEQ_BOOT_RESAMPLE_EN
            if (k == 40) check_eq("plan_valid_e40", 32'(bus.boot_mode_valid_o), 32'(0));
            if (k == 42) check_eq("plan_bm_e42", 32'(bus.boot_mode_o), 32'(2'b01));
            if (k == 58) check_eq("plan_rst_e58", 32'(bus.rst_no), 32'(2'b01));
            if (k == 66) check_eq("plan_rst_e66", 32'(bus.rst_no), 32'(2'b11));
`else
            if (k == 56) check_eq("plan_rst_e56", 32'(bus.rst_no), 32'(2'b01));
            if (k == 64) check_eq("plan_rst_e64", 32'(bus.rst_no), 32'(2'b11));
            if (k == 64) check_eq("plan_bm_e64", 32'(bus.boot_mode_o), 32'(2'b10));
`endif
        end

        // Request acting at edge 20, during the stagger.
        do_reset(2'b11);
        while (k < 50) begin
            cycle(2'b11, (k == 20 - S), 1'b0);
            #1;
            if (k == 18) check_eq("rel_rst_e18", 32'(bus.rst_no), 32'(2'b01));
            if (k == 20) check_eq("rel_rst_e20", 32'(bus.rst_no), 32'(2'b00));
            if (k == 36) check_eq("rel_rst_e36", 32'(bus.rst_no), 32'(2'b01));
            if (k == 44) check_eq("rel_rst_e44", 32'(bus.rst_no), 32'(2'b11));
        end

        // Pin reset at edge 22, then a clean restart.
        do_reset(2'b01);
        while (k < 22) cycle(2'b01, 1'b0, 1'b0);
        async_reset_check("arst_e22");
        do_reset(2'b01);
        while (k < 30) begin
            cycle(2'b01, 1'b0, 1'b0);
            #1;
            if (k == 18) check_eq("arst_restart_e18", 32'(bus.rst_no), 32'(2'b01));
        end

        // Test mode: domain resets follow the pin with no clock edge.
        @(negedge clk);
        bus.test_mode_i = 1'b1;
        tm_cur          = 1'b1;
        rst_ni          = 1'b0;
        #1;
        check_eq("tm_rst_low", 32'(bus.rst_no), 32'(2'b00));
        rst_ni = 1'b1;
        #1;
        check_eq("tm_rst_high", 32'(bus.rst_no), 32'(2'b11));
        rst_ni = 1'b0;
        #1;
        check_eq("tm_rst_low2", 32'(bus.rst_no), 32'(2'b00));

        // Randomized runs against the model.
        for (int run = 0; run < 10; run++) begin
            bm_cur   = W'($urandom_range(0, (1 << W) - 1));
            do_reset(bm_cur);
            len      = 120 + $urandom_range(0, 150);
            tm_start = $urandom_range(5, len);
            rst_pt   = (run % 3 == 2) ? $urandom_range(3, len - 1) : len + 10;
            req_left = 0;
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 19) == 0) bm_cur = W'($urandom_range(0, (1 << W) - 1));
                if (req_left == 0 && $urandom_range(0, 29) == 0)
                    req_left = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 3);
                rq = (req_left > 0);
                if (req_left > 0) req_left--;
                cycle(bm_cur, rq, (c >= tm_start && c < tm_start + 8));
                if (c == rst_pt) begin
                    async_reset_check($sformatf("rand_arst_r%0d", run));
                    do_reset(bm_cur);
                end
            end
            @(negedge clk);
            check_all("end");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
